// File: rtl/axis_pkt_fifo_pkg.sv
// Shared types and helpers for the AXI-Stream packet FIFO.
// The gate states only matter when the FIFO runs in store-and-forward mode.
package axis_pkt_fifo_pkg;

    typedef enum logic [1:0] {
        GATE_WAIT  = 2'd0,
        GATE_SEND  = 2'd1,
        GATE_FORCE = 2'd2
    } gate_state_t;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_pkt_fifo_mem.sv
// Storage array for the packet FIFO: synchronous write, asynchronous read.
// The asynchronous read gives first-word fall-through on the output side.
module axis_pkt_fifo_mem #(
    parameter int W     = 9,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO with occupancy/packet counters and an optional
// store-and-forward gate that falls back to cut-through for oversize packets.
//
// state      | meaning
// GATE_WAIT  | output held off until a complete packet is stored
// GATE_SEND  | releasing stored packets until the last complete one drains
// GATE_FORCE | buffer filled with no tlast stored; stream through to tlast
module axis_pkt_fifo
    import axis_pkt_fifo_pkg::*;
#(
    parameter int DW       = 8,
    parameter int DEPTH    = 8,
    parameter int PKT_MODE = 0,
    localparam int AW      = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tvalid,
    input  logic          s_tlast,
    output logic          s_tready,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    output logic          m_tlast,
    input  logic          m_tready,
    output logic [AW:0]   count,
    output logic [AW:0]   pkt_cnt,
    output logic          full,
    output logic          empty,
    output logic          oversize
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
    localparam bit          GATED     = (PKT_MODE != 0);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic [AW:0]   pkt_q;
    logic [AW:0]   count_next;
    logic [AW:0]   pkt_next;
    logic          ready_q;
    logic          oversize_q;
    gate_state_t   state;
    logic          push;
    logic          pop;
    logic          push_last;
    logic          pop_last;
    logic [DW:0]   rd_word;

    axis_pkt_fifo_mem #(
        .W     (DW + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({s_tlast, s_tdata}),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    assign m_tdata  = rd_word[DW-1:0];
    assign m_tlast  = rd_word[DW];
    assign full     = (count_q == DEPTH_CNT);
    assign empty    = (count_q == '0);
    assign s_tready = ready_q;
    assign count    = count_q;
    assign pkt_cnt  = pkt_q;
    assign oversize = oversize_q;
    assign m_tvalid = !empty && (!GATED || state != GATE_WAIT);

    assign push      = s_tvalid && ready_q;
    assign pop       = m_tvalid && m_tready;
    assign push_last = push && s_tlast;
    assign pop_last  = pop && m_tlast;

    always_comb begin
        count_next = count_q;
        pkt_next   = pkt_q;
        if (push && !pop) begin
            count_next = count_q + 1'b1;
        end else if (pop && !push) begin
            count_next = count_q - 1'b1;
        end
        if (push_last && !pop_last) begin
            pkt_next = pkt_q + 1'b1;
        end else if (pop_last && !push_last) begin
            pkt_next = pkt_q - 1'b1;
        end
    end

    // Ready comes from the next occupancy so it never depends on m_tready combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            pkt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_next;
            pkt_q   <= pkt_next;
            ready_q <= (count_next != DEPTH_CNT);
        end
    end

    // Transitions look at post-edge counts so a packet is released the cycle after its tlast lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= GATE_WAIT;
            oversize_q <= 1'b0;
        end else begin
            oversize_q <= 1'b0;
            if (GATED) begin
                case (state)
                    GATE_WAIT: begin
                        if (pkt_next != '0) begin
                            state <= GATE_SEND;
                        end else if (count_next == DEPTH_CNT) begin
                            state      <= GATE_FORCE;
                            oversize_q <= 1'b1;
                        end
                    end
                    GATE_SEND, GATE_FORCE: begin
                        if (pop_last) begin
                            state <= (pkt_next != '0) ? GATE_SEND : GATE_WAIT;
                        end
                    end
                    default: state <= GATE_WAIT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: one cut-through and one store-and-forward instance,
// checked every cycle against a queue-based model plus directed literal checks.
module tb_axis_pkt_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_tdata  [2];
    logic       s_tvalid [2];
    logic       s_tlast  [2];
    logic       s_tready [2];
    logic [7:0] m_tdata  [2];
    logic       m_tvalid [2];
    logic       m_tlast  [2];
    logic       m_tready [2];
    logic [3:0] count    [2];
    logic [3:0] pkt_cnt  [2];
    logic       full     [2];
    logic       empty    [2];
    logic       oversize [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axis_pkt_fifo #(.DW(8), .DEPTH(8), .PKT_MODE(0)) dut0 (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata[0]), .s_tvalid(s_tvalid[0]), .s_tlast(s_tlast[0]), .s_tready(s_tready[0]),
        .m_tdata(m_tdata[0]), .m_tvalid(m_tvalid[0]), .m_tlast(m_tlast[0]), .m_tready(m_tready[0]),
        .count(count[0]), .pkt_cnt(pkt_cnt[0]), .full(full[0]), .empty(empty[0]), .oversize(oversize[0])
    );

    axis_pkt_fifo #(.DW(8), .DEPTH(8), .PKT_MODE(1)) dut1 (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata[1]), .s_tvalid(s_tvalid[1]), .s_tlast(s_tlast[1]), .s_tready(s_tready[1]),
        .m_tdata(m_tdata[1]), .m_tvalid(m_tvalid[1]), .m_tlast(m_tlast[1]), .m_tready(m_tready[1]),
        .count(count[1]), .pkt_cnt(pkt_cnt[1]), .full(full[1]), .empty(empty[1]), .oversize(oversize[1])
    );

    task automatic chk(input string nm, input int i, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h", nm, i, act, exp);
        end
    endtask

    // Model: every beat ever accepted, indexed by an ever-growing head/tail.
    logic [8:0] mq [2][1024];
    int mh [2];
    int mt [2];
    bit mopen [2];
    bit movs  [2];
    bit mrdy  [2];

    function automatic int mcnt(input int i);
        return mt[i] - mh[i];
    endfunction

    function automatic int mpk(input int i);
        int n;
        n = 0;
        for (int k = mh[i]; k < mt[i]; k++) begin
            if (mq[i][k][8]) n = n + 1;
        end
        return n;
    endfunction

    function automatic bit mvalid(input int i);
        return (mcnt(i) > 0) && (i == 0 || mopen[i]);
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            mh[i] = 0; mt[i] = 0; mopen[i] = 0; movs[i] = 0; mrdy[i] = 0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    mh[i] = 0; mt[i] = 0; mopen[i] = 0; movs[i] = 0; mrdy[i] = 0;
                end else begin
                    bit do_push;
                    bit do_pop;
                    bit last_out;
                    do_push  = s_tvalid[i] && mrdy[i];
                    do_pop   = mvalid(i) && m_tready[i];
                    last_out = do_pop && mq[i][mh[i]][8];
                    if (do_pop) mh[i] = mh[i] + 1;
                    if (do_push) begin
                        mq[i][mt[i]] = {s_tlast[i], s_tdata[i]};
                        mt[i] = mt[i] + 1;
                    end
                    movs[i] = 0;
                    if (i == 1) begin
                        if (mopen[i]) begin
                            if (last_out) mopen[i] = (mpk(i) > 0);
                        end else if (mpk(i) > 0) begin
                            mopen[i] = 1;
                        end else if (mcnt(i) == 8) begin
                            mopen[i] = 1;
                            movs[i]  = 1;
                        end
                    end
                    mrdy[i] = (mcnt(i) < 8);
                end
            end
        end
    end

    logic [8:0] rx0 [$];
    logic [8:0] rx1 [$];
    int ovs_seen = 0;
    int ovs_cnt  = 0;

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    chk("rst_s_tready", i, s_tready[i], 0);
                    chk("rst_m_tvalid", i, m_tvalid[i], 0);
                    chk("rst_count", i, count[i], 0);
                    chk("rst_pkt_cnt", i, pkt_cnt[i], 0);
                    chk("rst_empty", i, empty[i], 1);
                    chk("rst_full", i, full[i], 0);
                    chk("rst_oversize", i, oversize[i], 0);
                end else begin
                    chk("s_tready", i, s_tready[i], mrdy[i]);
                    chk("m_tvalid", i, m_tvalid[i], mvalid(i));
                    chk("count", i, count[i], mcnt(i));
                    chk("pkt_cnt", i, pkt_cnt[i], mpk(i));
                    chk("empty", i, empty[i], mcnt(i) == 0);
                    chk("full", i, full[i], mcnt(i) == 8);
                    chk("oversize", i, oversize[i], movs[i]);
                    if (mvalid(i)) begin
                        chk("m_tdata", i, m_tdata[i], mq[i][mh[i]][7:0]);
                        chk("m_tlast", i, m_tlast[i], mq[i][mh[i]][8]);
                    end
                end
            end
            if (m_tvalid[0] && m_tready[0]) rx0.push_back({m_tlast[0], m_tdata[0]});
            if (m_tvalid[1] && m_tready[1]) rx1.push_back({m_tlast[1], m_tdata[1]});
            if (oversize[1]) begin
                ovs_seen = ovs_seen + 1;
                ovs_cnt  = count[1];
            end
        end
    end

    logic [8:0] txq [$];
    logic [8:0] exq [$];
    bit gate_chk   = 0;
    int hold_count = -1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_all(input int i);
        int guard;
        bit hs;
        guard = 0;
        while (txq.size() > 0 && guard < 200) begin
            s_tvalid[i] = 1'b1;
            s_tdata[i]  = txq[0][7:0];
            s_tlast[i]  = txq[0][8];
            @(negedge clk);
            hs = s_tready[i];
            if (gate_chk) chk("t3_gate_closed", i, m_tvalid[i], 0);
            if (hold_count >= 0) chk("t4_steady_count", i, count[i], hold_count);
            step();
            if (hs) void'(txq.pop_front());
            guard = guard + 1;
        end
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
        chk("send_done", i, txq.size(), 0);
    endtask

    task automatic drain(input int i);
        int guard;
        guard = 0;
        while (count[i] != 0 && guard < 100) begin
            step();
            guard = guard + 1;
        end
        chk("drain_done", i, count[i], 0);
    endtask

    task automatic chk_rx(input string nm, input int i);
        int n;
        n = (i == 0) ? rx0.size() : rx1.size();
        chk({nm, "_len"}, i, n, exq.size());
        for (int k = 0; k < exq.size() && k < n; k++) begin
            chk(nm, i, (i == 0) ? rx0[k] : rx1[k], exq[k]);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            s_tdata[i] = 8'h00; s_tvalid[i] = 1'b0; s_tlast[i] = 1'b0; m_tready[i] = 1'b0;
        end

        // 1: reset held 3 cycles, ready only after release plus one edge
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t1_s_tready_in_rst", 0, s_tready[0], 0);
        chk("t1_m_tvalid", 1, m_tvalid[1], 0);
        chk("t1_count", 0, count[0], 0);
        chk("t1_empty", 1, empty[1], 1);
        step();
        rst = 1'b0;
        step();
        @(negedge clk);
        chk("t1_s_tready_after", 0, s_tready[0], 1);
        chk("t1_s_tready_after", 1, s_tready[1], 1);
        step();

        // 2: cut-through fill to full with the consumer stalled, then drain
        rx0.delete();
        for (int k = 0; k < 10; k++) txq.push_back({k == 9, 8'(2 + 2 * k)});
        fork
            send_all(0);
            begin
                repeat (12) step();
                chk("t2_count_full", 0, count[0], 8);
                chk("t2_full", 0, full[0], 1);
                chk("t2_s_tready", 0, s_tready[0], 0);
                m_tready[0] = 1'b1;
            end
        join
        drain(0);
        exq.delete();
        for (int k = 0; k < 10; k++) exq.push_back({k == 9, 8'(2 + 2 * k)});
        chk_rx("t2_rx", 0);
        chk("t2_first", 0, rx0[0], 9'h002);
        chk("t2_last", 0, rx0[9], 9'h114);

        // 3: store-and-forward holds a short packet until its tlast is stored
        rx1.delete();
        m_tready[1] = 1'b1;
        txq.push_back(9'h0A0); txq.push_back(9'h0A1); txq.push_back(9'h1A2);
        gate_chk = 1;
        send_all(1);
        gate_chk = 0;
        @(negedge clk);
        chk("t3_m_tvalid_open", 1, m_tvalid[1], 1);
        chk("t3_pkt_cnt", 1, pkt_cnt[1], 1);
        chk("t3_head", 1, m_tdata[1], 8'hA0);
        step();
        drain(1);
        chk("t3_pkt_cnt_drained", 1, pkt_cnt[1], 0);
        exq.delete();
        exq.push_back(9'h0A0); exq.push_back(9'h0A1); exq.push_back(9'h1A2);
        chk_rx("t3_rx", 1);

        // 4: hold four entries while pushing and popping every cycle
        rx0.delete();
        m_tready[0] = 1'b0;
        for (int k = 0; k < 4; k++) txq.push_back({1'b0, 8'(8'h30 + k)});
        send_all(0);
        m_tready[0] = 1'b1;
        hold_count = 4;
        for (int k = 4; k < 10; k++) txq.push_back({k == 9, 8'(8'h30 + k)});
        send_all(0);
        hold_count = -1;
        m_tready[0] = 1'b0;
        @(negedge clk);
        chk("t4_count", 0, count[0], 4);
        step();
        m_tready[0] = 1'b1;
        drain(0);
        exq.delete();
        for (int k = 0; k < 10; k++) exq.push_back({k == 9, 8'(8'h30 + k)});
        chk_rx("t4_rx", 0);

        // 5: packet longer than the buffer falls back to cut-through
        rx1.delete();
        ovs_seen = 0;
        for (int k = 0; k < 12; k++) txq.push_back({k == 11, 8'(8'h50 + k)});
        send_all(1);
        drain(1);
        step();
        chk("t5_oversize_pulses", 1, ovs_seen, 1);
        chk("t5_oversize_at_full", 1, ovs_cnt, 8);
        exq.delete();
        for (int k = 0; k < 12; k++) exq.push_back({k == 11, 8'(8'h50 + k)});
        chk_rx("t5_rx", 1);
        chk("t5_last_beat", 1, rx1[11], 9'h15B);

        // 6: reset mid-packet discards the partial packet
        rx1.delete();
        txq.push_back(9'h060); txq.push_back(9'h061); txq.push_back(9'h062);
        send_all(1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_count", 1, count[1], 0);
        chk("t6_pkt_cnt", 1, pkt_cnt[1], 0);
        chk("t6_m_tvalid", 1, m_tvalid[1], 0);
        step();
        for (int k = 0; k < 4; k++) txq.push_back({k == 3, 8'(8'h70 + k)});
        send_all(1);
        drain(1);
        exq.delete();
        for (int k = 0; k < 4; k++) exq.push_back({k == 3, 8'(8'h70 + k)});
        chk_rx("t6_rx", 1);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
